peripheral_uart_bridge_wb_gen: RTL and testbench
================================================

PERIPHERAL_UART_BRIDGE_WB_GEN -- requirements
Module: peripheral_uart_bridge_wb_gen

Interface
REQ-001 Parameter DW, 8, Wishbone data width; legal values 8 or 32.
REQ-002 Parameter AW, 3, Wishbone/internal register address width; legal range 3..8.
REQ-003 Parameter NUM_REGS, 8, number of implemented registers; legal range 1..2^AW.
REQ-004 Parameter WAIT_STATES, 0, extra cycles between register strobe and response; legal range 0..7.
REQ-005 Reset and clock are decided: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  clock; all logic on its rising edge.
REQ-007 wb_rst_ni  in  1  asynchronous reset, active-low.
REQ-008 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone cycle, strobe and write-enable.
REQ-009 wb_sel_i  in  DW/8  byte-lane select.
REQ-010 wb_adr_i  in  AW  register address.
REQ-011 wb_dat_i  in  DW  write data.
REQ-012 wb_dat_o  out  DW  read data, registered.
REQ-013 wb_ack_o, wb_err_o  out  1 each  registered one-cycle response.
REQ-014 wb_adr_int  out  AW  sampled address to the register file.
REQ-015 wb_dat8_i  out  8  write byte to the register file.
REQ-016 wb_dat8_o  in  8  read byte from the register file.
REQ-017 we_o, re_o  out  1 each  one-cycle register write and read strobes.

Function
REQ-018 wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i and wb_dat_i are registered every cycle into sampled copies (_is); all decisions use only the sampled copies.
REQ-019 The FSM has five states.
- IDLE: go to ACCESS when cyc_is & stb_is.
- ACCESS: lasts one cycle; go to WAIT if WAIT_STATES>0, else to RESP.
- WAIT: a down-counter runs WAIT_STATES cycles, then goes to RESP.
- RESP: lasts one cycle.
- HOLD: stay until ~(cyc_is & stb_is), then go to IDLE.
REQ-020 In ACCESS only: we_o = we_is & valid, re_o = ~we_is & valid; both are 0 in all other states, so exactly one strobe is issued per transaction.
REQ-021 valid = (adr_is < NUM_REGS) & exactly one bit set in sel_is; for DW=8 the select term is ignored.
REQ-022 Lane = index of the set bit in sel_is (0 for DW=8).
- wb_dat8_i = dat_is[8*lane +: 8].
- wb_adr_int = adr_is.
REQ-023 On the ACCESS/WAIT-to-RESP edge, wb_dat_o is loaded with wb_dat8_o in byte lane "lane" and zeros elsewhere; write transactions load zero.
REQ-024 During RESP, exactly one of wb_ack_o (valid) or wb_err_o (not valid) is high, for exactly one cycle.
REQ-025 Latency: if the sampling edge for the request is k, the response is high in the cycle after edge k+2+WAIT_STATES.
REQ-026 If cyc_is falls in ACCESS or WAIT: go to IDLE, issue no response, and do not undo any strobe already issued.
REQ-027 A strobe held high after a response does not start a second access; HOLD requires it to drop first.
REQ-028 Back-to-back transactions are separated by at least one IDLE cycle.

Reset
REQ-029 While wb_rst_ni=0 the block is asynchronously held as follows:
- FSM in IDLE, wait counter 0.
- All _is registers 0.
- wb_dat_o, wb_ack_o, wb_err_o, we_o and re_o all 0.
REQ-030 Reset asserted mid-transaction aborts it with no response; the first possible ack follows the REQ-025 timing after reset release.

Configuration
REQ-031 Macro PERIPHERAL_UART_BRIDGE_ERR_EN.
- Defined: REQ-021 checks and wb_err_o are active as specified.
- Undefined: valid is forced to 1, wb_err_o is tied 0, every transaction is acked, out-of-range addresses still strobe, and lane = lowest set bit of sel (0 if none).

Structure
REQ-032 peripheral_wb_pkg holds the FSM state enum type, the DW/AW legality constants and the lane-index function.
REQ-033 One sub-module, peripheral_uart_bridge_wb_lane (sel-to-lane decode and one-hot check), is instantiated once.

Verification
REQ-034 DW=8, WAIT_STATES=0: write 0x5A to address 3.
- One we_o pulse with wb_adr_int=3 and wb_dat8_i=0x5A.
- wb_ack_o high at edge k+2, for one cycle.
REQ-035 DW=32, WAIT_STATES=3: read address 1, sel=4'b0100, wb_dat8_o=0xC3.
- One re_o pulse.
- wb_dat_o=0x00C30000; wb_ack_o at edge k+5.
REQ-036 With ERR_EN, NUM_REGS=6: read address 7.
- No re_o.
- wb_err_o one cycle; wb_ack_o stays 0.
REQ-037 With ERR_EN, DW=32: sel=4'b0011 gives wb_err_o and no we_o; the same stimulus without the macro gives ack and lane 0.
REQ-038 Abort and reset cases:
- stb held high for 20 cycles gives exactly one strobe and one ack.
- cyc dropped during WAIT gives no response.
- wb_rst_ni pulsed low in WAIT forces all outputs to 0 immediately, with no ack afterwards.

Source files
------------

// File: rtl/peripheral_wb_pkg.sv
// Shared types and helpers for the Wishbone-to-byte-register bridge:
// FSM state encoding, legal width bounds and the byte-lane index function.
package peripheral_wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP,
    ST_HOLD
  } wb_state_e;

  localparam int DW_NARROW = 8;
  localparam int DW_WIDE   = 32;
  localparam int AW_MIN    = 3;
  localparam int AW_MAX    = 8;
  localparam int LANE_W    = 2;

  // Lowest set bit wins; an empty select maps to lane 0.
  function automatic logic [LANE_W-1:0] lane_idx(input logic [3:0] sel);
    logic [LANE_W-1:0] idx;
    idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (sel[i]) idx = LANE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/peripheral_uart_bridge_wb_lane.sv
// Byte-select decode: lane index of the selected byte and a one-hot flag.
// A single-lane bus has nothing to decode, so it always reports lane 0, one-hot.
module peripheral_uart_bridge_wb_lane
  import peripheral_wb_pkg::*;
#(
  parameter int SW = 4
) (
  input  logic [SW-1:0]     sel,
  output logic [LANE_W-1:0] lane,
  output logic              onehot
);

  generate
    if (SW == 1) begin : g_narrow
      logic unused_sel;
      assign unused_sel = ^sel;
      assign lane       = '0;
      assign onehot     = 1'b1;
    end else begin : g_wide
      logic [3:0] sel4;
      assign sel4   = 4'(sel);
      assign lane   = lane_idx(sel4);
      assign onehot = (sel4 != 4'd0) && ((sel4 & (sel4 - 4'd1)) == 4'd0);
    end
  endgenerate

endmodule

// File: rtl/peripheral_uart_bridge_wb_gen.sv
// Wishbone slave bridging to an 8-bit register file with optional wait states.
// Define PERIPHERAL_UART_BRIDGE_ERR_EN to enable address/select checking and wb_err_o.
module peripheral_uart_bridge_wb_gen
  import peripheral_wb_pkg::*;
#(
  parameter int DW          = 8,
  parameter int AW          = 3,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            wb_rst_ni,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic [AW-1:0]   wb_adr_int,
  output logic [7:0]      wb_dat8_i,
  input  logic [7:0]      wb_dat8_o,
  output logic            we_o,
  output logic            re_o
);

  localparam int SW = DW / 8;
  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  logic            cyc_is, stb_is, we_is;
  logic [SW-1:0]   sel_is;
  logic [AW-1:0]   adr_is;
  logic [DW-1:0]   dat_is;

  wb_state_e       state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [LANE_W-1:0] lane;
  logic            onehot;
  logic            valid;
  logic            resp_load;
  logic [4:0]      lane_shift;
  logic [DW-1:0]   dat_shifted;
  logic [DW-1:0]   rd_word;

  // Every decision below looks only at these sampled copies of the bus.
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cyc_is <= 1'b0;
      stb_is <= 1'b0;
      we_is  <= 1'b0;
      sel_is <= '0;
      adr_is <= '0;
      dat_is <= '0;
    end else begin
      cyc_is <= wb_cyc_i;
      stb_is <= wb_stb_i;
      we_is  <= wb_we_i;
      sel_is <= wb_sel_i;
      adr_is <= wb_adr_i;
      dat_is <= wb_dat_i;
    end
  end

  peripheral_uart_bridge_wb_lane #(.SW(SW)) u_lane (
    .sel    (sel_is),
    .lane   (lane),
    .onehot (onehot)
  );

`ifdef PERIPHERAL_UART_BRIDGE_ERR_EN
  localparam logic [AW:0] NUM_REGS_W = NUM_REGS[AW:0];
  assign valid = ({1'b0, adr_is} < NUM_REGS_W) && onehot;
`else
  logic unused_onehot;
  assign unused_onehot = onehot;
  assign valid         = 1'b1;
`endif

  assign lane_shift  = {lane, 3'b000};
  assign dat_shifted = dat_is >> lane_shift;
  assign wb_dat8_i   = dat_shifted[7:0];
  assign wb_adr_int  = adr_is;
  assign rd_word     = DW'(wb_dat8_o) << lane_shift;

  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes are decoded from ACCESS only, so an abort cannot retract one already issued.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_o    = 1'b0;
    re_o    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cyc_is && stb_is) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        we_o = we_is & valid;
        re_o = ~we_is & valid;
        if (!cyc_is) begin
          state_d = ST_IDLE;
        end else if (WAIT_STATES > 0) begin
          state_d = ST_WAIT;
          cnt_d   = WS_LOAD;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (!cyc_is) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q == 3'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: state_d = ST_HOLD;
      ST_HOLD: begin
        if (!(cyc_is && stb_is)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign resp_load = (state_d == ST_RESP) && (state_q != ST_RESP);

  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= resp_load & valid;
      wb_err_o <= resp_load & ~valid;
      if (resp_load) wb_dat_o <= we_is ? '0 : rd_word;
    end
  end

endmodule

// File: tb/tb_peripheral_uart_bridge_wb_gen.sv
// Directed bench: an 8-bit/no-wait instance and a 32-bit/3-wait/6-register instance.
module tb_peripheral_uart_bridge_wb_gen;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc_cnt = 0;
  int   n_total = 0;
  int   n_bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // narrow instance (n_) signals
  logic       n_cyc, n_stb, n_we;
  logic [0:0] n_sel;
  logic [2:0] n_adr, n_adr_int;
  logic [7:0] n_dat, n_dato, n_d8i, n_d8o;
  logic       n_ack, n_err, n_weo, n_reo;

  // wide instance (w_) signals
  logic        w_cyc, w_stb, w_we;
  logic [3:0]  w_sel;
  logic [2:0]  w_adr, w_adr_int;
  logic [31:0] w_dat, w_dato;
  logic [7:0]  w_d8i, w_d8o;
  logic        w_ack, w_err, w_weo, w_reo;

  peripheral_uart_bridge_wb_gen #(.DW(8), .AW(3), .NUM_REGS(8), .WAIT_STATES(0)) dut_n (
    .clk(clk), .wb_rst_ni(rst_n), .wb_cyc_i(n_cyc), .wb_stb_i(n_stb), .wb_we_i(n_we),
    .wb_sel_i(n_sel), .wb_adr_i(n_adr), .wb_dat_i(n_dat), .wb_dat_o(n_dato),
    .wb_ack_o(n_ack), .wb_err_o(n_err), .wb_adr_int(n_adr_int), .wb_dat8_i(n_d8i),
    .wb_dat8_o(n_d8o), .we_o(n_weo), .re_o(n_reo)
  );

  peripheral_uart_bridge_wb_gen #(.DW(32), .AW(3), .NUM_REGS(6), .WAIT_STATES(3)) dut_w (
    .clk(clk), .wb_rst_ni(rst_n), .wb_cyc_i(w_cyc), .wb_stb_i(w_stb), .wb_we_i(w_we),
    .wb_sel_i(w_sel), .wb_adr_i(w_adr), .wb_dat_i(w_dat), .wb_dat_o(w_dato),
    .wb_ack_o(w_ack), .wb_err_o(w_err), .wb_adr_int(w_adr_int), .wb_dat8_i(w_d8i),
    .wb_dat8_o(w_d8o), .we_o(w_weo), .re_o(w_reo)
  );

  // pulse monitors, sampled on the falling edge
  int n_we_cnt, n_re_cnt, n_ack_cnt, n_err_cnt, n_ack_at;
  logic [31:0] n_adr_cap, n_d8_cap, n_dato_cap;
  int w_we_cnt, w_re_cnt, w_ack_cnt, w_err_cnt, w_ack_at;
  logic [31:0] w_adr_cap, w_d8_cap, w_dato_cap;

  always @(negedge clk) begin
    if (n_weo) begin n_we_cnt++; n_adr_cap = 32'(n_adr_int); n_d8_cap = 32'(n_d8i); end
    if (n_reo) begin n_re_cnt++; n_adr_cap = 32'(n_adr_int); end
    if (n_ack) begin n_ack_cnt++; n_ack_at = cyc_cnt; n_dato_cap = 32'(n_dato); end
    if (n_err) n_err_cnt++;
    if (w_weo) begin w_we_cnt++; w_adr_cap = 32'(w_adr_int); w_d8_cap = 32'(w_d8i); end
    if (w_reo) begin w_re_cnt++; w_adr_cap = 32'(w_adr_int); end
    if (w_ack) begin w_ack_cnt++; w_ack_at = cyc_cnt; w_dato_cap = w_dato; end
    if (w_err) w_err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    n_we_cnt = 0; n_re_cnt = 0; n_ack_cnt = 0; n_err_cnt = 0; n_ack_at = -1;
    w_we_cnt = 0; w_re_cnt = 0; w_ack_cnt = 0; w_err_cnt = 0; w_ack_at = -1;
  endtask

  task automatic run_n(input logic we, input logic [2:0] adr, input logic [7:0] dat,
                       output int k);
    @(posedge clk); #1;
    clear_counts();
    k = cyc_cnt + 1;
    n_cyc = 1'b1; n_stb = 1'b1; n_we = we; n_sel = 1'b1; n_adr = adr; n_dat = dat;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (n_ack || n_err) break;
    end
    @(posedge clk); #1;
    n_cyc = 1'b0; n_stb = 1'b0; n_we = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic run_w(input logic we, input logic [2:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, output int k);
    @(posedge clk); #1;
    clear_counts();
    k = cyc_cnt + 1;
    w_cyc = 1'b1; w_stb = 1'b1; w_we = we; w_sel = sel; w_adr = adr; w_dat = dat;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (w_ack || w_err) break;
    end
    @(posedge clk); #1;
    w_cyc = 1'b0; w_stb = 1'b0; w_we = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    n_cyc = 0; n_stb = 0; n_we = 0; n_sel = '0; n_adr = '0; n_dat = '0; n_d8o = '0;
    w_cyc = 0; w_stb = 0; w_we = 0; w_sel = '0; w_adr = '0; w_dat = '0; w_d8o = '0;
    clear_counts();
    #1;
    chk("rst_n_ack",   32'(n_ack), 32'd0);
    chk("rst_n_dato",  32'(n_dato), 32'd0);
    chk("rst_n_we_re", 32'({n_weo, n_reo}), 32'd0);
    chk("rst_w_ack_err", 32'({w_ack, w_err}), 32'd0);
    chk("rst_w_dato",  w_dato, 32'd0);
    chk("rst_w_adr_d8", 32'({w_adr_int, w_d8i}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // narrow write: 0x5A to address 3, ack two edges after sampling
    run_n(1'b1, 3'd3, 8'h5A, k);
    chk("n_wr_we_cnt", 32'(n_we_cnt), 32'd1);
    chk("n_wr_re_cnt", 32'(n_re_cnt), 32'd0);
    chk("n_wr_adr",    n_adr_cap, 32'd3);
    chk("n_wr_d8",     n_d8_cap, 32'h5A);
    chk("n_wr_ack_cnt", 32'(n_ack_cnt), 32'd1);
    chk("n_wr_ack_at", 32'(n_ack_at), 32'(k + 2));
    chk("n_wr_err_cnt", 32'(n_err_cnt), 32'd0);

    // narrow read of address 6
    n_d8o = 8'h3C;
    run_n(1'b0, 3'd6, 8'h00, k);
    chk("n_rd_re_cnt", 32'(n_re_cnt), 32'd1);
    chk("n_rd_dato",   n_dato_cap, 32'h3C);
    chk("n_rd_ack_at", 32'(n_ack_at), 32'(k + 2));

    // wide write to lane 1
    run_w(1'b1, 3'd2, 4'b0010, 32'h0000A500, k);
    chk("w_wr_we_cnt", 32'(w_we_cnt), 32'd1);
    chk("w_wr_adr",    w_adr_cap, 32'd2);
    chk("w_wr_d8",     w_d8_cap, 32'hA5);
    chk("w_wr_ack_cnt", 32'(w_ack_cnt), 32'd1);
    chk("w_wr_dato",   w_dato_cap, 32'd0);
    chk("w_wr_ack_at", 32'(w_ack_at), 32'(k + 5));

    // out-of-range read (address 7 of 6 registers)
    w_d8o = 8'h11;
    run_w(1'b0, 3'd7, 4'b0001, 32'd0, k);
`ifdef PERIPHERAL_UART_BRIDGE_ERR_EN
    chk("w_oor_re_cnt",  32'(w_re_cnt), 32'd0);
    chk("w_oor_err_cnt", 32'(w_err_cnt), 32'd1);
    chk("w_oor_ack_cnt", 32'(w_ack_cnt), 32'd0);
`else
    chk("w_oor_re_cnt",  32'(w_re_cnt), 32'd1);
    chk("w_oor_err_cnt", 32'(w_err_cnt), 32'd0);
    chk("w_oor_ack_cnt", 32'(w_ack_cnt), 32'd1);
    chk("w_oor_dato",    w_dato_cap, 32'h00000011);
`endif

    // two-hot select write
    run_w(1'b1, 3'd2, 4'b0011, 32'h00001234, k);
`ifdef PERIPHERAL_UART_BRIDGE_ERR_EN
    chk("w_2hot_err_cnt", 32'(w_err_cnt), 32'd1);
    chk("w_2hot_we_cnt",  32'(w_we_cnt), 32'd0);
    chk("w_2hot_ack_cnt", 32'(w_ack_cnt), 32'd0);
`else
    chk("w_2hot_ack_cnt", 32'(w_ack_cnt), 32'd1);
    chk("w_2hot_we_cnt",  32'(w_we_cnt), 32'd1);
    chk("w_2hot_d8",      w_d8_cap, 32'h34);
    chk("w_2hot_err_cnt", 32'(w_err_cnt), 32'd0);
`endif

    // strobe held for 20 cycles: single access, single ack
    @(posedge clk); #1;
    clear_counts();
    w_cyc = 1'b1; w_stb = 1'b1; w_we = 1'b1; w_sel = 4'b0100; w_adr = 3'd5; w_dat = 32'h00990000;
    repeat (20) @(posedge clk);
    #1 w_cyc = 1'b0; w_stb = 1'b0; w_we = 1'b0;
    repeat (5) @(posedge clk);
    chk("w_hold_we_cnt",  32'(w_we_cnt), 32'd1);
    chk("w_hold_ack_cnt", 32'(w_ack_cnt), 32'd1);
    chk("w_hold_d8",      w_d8_cap, 32'h99);

    // cyc dropped while waiting: strobe stays issued, no response
    @(posedge clk); #1;
    clear_counts();
    w_cyc = 1'b1; w_stb = 1'b1; w_we = 1'b0; w_sel = 4'b1000; w_adr = 3'd4;
    repeat (3) @(posedge clk);
    #1 w_cyc = 1'b0; w_stb = 1'b0;
    repeat (10) @(posedge clk);
    chk("w_abort_re_cnt",  32'(w_re_cnt), 32'd1);
    chk("w_abort_ack_cnt", 32'(w_ack_cnt), 32'd0);
    chk("w_abort_err_cnt", 32'(w_err_cnt), 32'd0);

    // wide read on lane 2, three wait states
    w_d8o = 8'hC3;
    exp_q.push_back(32'h00C30000);
    run_w(1'b0, 3'd1, 4'b0100, 32'd0, k);
    chk("w_rd_re_cnt",  32'(w_re_cnt), 32'd1);
    chk("w_rd_adr",     w_adr_cap, 32'd1);
    chk("w_rd_dato",    w_dato_cap, exp_q.pop_front());
    chk("w_rd_ack_at",  32'(w_ack_at), 32'(k + 5));
    chk("w_rd_dato_hold", w_dato, 32'h00C30000);

    // reset pulsed while in WAIT
    @(posedge clk); #1;
    clear_counts();
    w_cyc = 1'b1; w_stb = 1'b1; w_we = 1'b0; w_sel = 4'b0001; w_adr = 3'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0; w_cyc = 1'b0; w_stb = 1'b0;
    #1;
    chk("w_rstmid_dato",    w_dato, 32'd0);
    chk("w_rstmid_ack_err", 32'({w_ack, w_err}), 32'd0);
    chk("w_rstmid_we_re",   32'({w_weo, w_reo}), 32'd0);
    chk("w_rstmid_adr_d8",  32'({w_adr_int, w_d8i}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    chk("w_rstmid_ack_cnt", 32'(w_ack_cnt), 32'd0);
    chk("w_rstmid_err_cnt", 32'(w_err_cnt), 32'd0);

    // first read after reset keeps the normal latency
    w_d8o = 8'h7E;
    exp_q.push_back(32'h7E000000);
    run_w(1'b0, 3'd0, 4'b1000, 32'd0, k);
    chk("w_post_rst_dato",   w_dato_cap, exp_q.pop_front());
    chk("w_post_rst_ack_at", 32'(w_ack_at), 32'(k + 5));
    chk("w_post_rst_ack_cnt", 32'(w_ack_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
